fetch_sequencer: RTL and testbench

Instruction-fetch sequencer that drives the program-counter select protocol from the other side. It owns the architectural fetch PC, applies PS-encoded next-PC commands (00 hold, 01 increment, 10 absolute load, 11 relative add) arriving from execute, and issues word-addressed requests to instruction memory. It delivers each fetched instruction and its PC to decode over a valid/ready handshake. It sits between the execute-stage branch logic, instruction memory, and decode.

---
 rtl/fetch_sequencer.sv | 87 ++++++++
 tb/tb_fetch_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, issues word-addressed imem requests and hands
// fetched instructions to decode, obeying PS-encoded redirects from execute.
module fetch_sequencer #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned INSTR_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               br_valid,
   input  logic [1:0]         br_ps,
   input  logic [ADDR_W-1:0]  br_pc,
   input  logic [ADDR_W-1:0]  br_operand,
   output logic               imem_req_valid,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [ADDR_W-1:0]  if_pc4,
   output logic [ADDR_W-1:0]  fetch_pc,
   output logic               halted
);
   typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_e;
   state_e state_q;
   logic [ADDR_W-1:0] pc_q, if_pc_q, if_pc4_q, br_tgt_d;
   logic [INSTR_W-1:0] if_instr_q;
   logic drop_q, halt_pend_q, if_valid_q, br_halt_d, in_flight_d;
   assign br_halt_d = br_ps == 2'b00;
   assign br_tgt_d = br_ps == 2'b01 ? br_pc + ADDR_W'(1) :
                     br_ps == 2'b10 ? br_operand :
                     br_ps == 2'b11 ? br_pc + br_operand : pc_q;
   // A redirect that leaves a request outstanding must swallow its response later.
   assign in_flight_d = (state_q == WAIT && !imem_rsp_valid) || (state_q == REQ && imem_req_ready);
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= REQ;
         pc_q        <= RESET_PC;
         drop_q      <= 1'b0;
         halt_pend_q <= 1'b0;
         if_valid_q  <= 1'b0;
         if_instr_q  <= '0;
         if_pc_q     <= '0;
         if_pc4_q    <= ADDR_W'(4);
      end else if (br_valid) begin
         if_valid_q  <= 1'b0;
         pc_q        <= br_tgt_d;
         drop_q      <= in_flight_d;
         halt_pend_q <= in_flight_d && br_halt_d;
         state_q     <= in_flight_d ? WAIT : br_halt_d ? HALT : REQ;
      end else begin
         case (state_q)
            REQ: if (imem_req_ready) state_q <= WAIT;
            WAIT: if (imem_rsp_valid) begin
               if (drop_q) begin
                  drop_q      <= 1'b0;
                  halt_pend_q <= 1'b0;
                  state_q     <= halt_pend_q ? HALT : REQ;
               end else begin
                  if_valid_q <= 1'b1;
                  if_instr_q <= imem_rsp_data;
                  if_pc_q    <= pc_q;
                  if_pc4_q   <= pc_q + ADDR_W'(4);
                  pc_q       <= pc_q + ADDR_W'(1);
                  state_q    <= HOLD;
               end
            end
            HOLD: if (if_ready) begin
               if_valid_q <= 1'b0;
               state_q    <= REQ;
            end
            default: ;
         endcase
      end
   end
   assign imem_req_valid = state_q == REQ;
   assign imem_req_addr  = pc_q;
   assign halted         = state_q == HALT;
   assign fetch_pc       = pc_q;
   assign if_valid       = if_valid_q;
   assign if_instr       = if_instr_q;
   assign if_pc          = if_pc_q;
   assign if_pc4         = if_pc4_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed steps with a bench-driven zero-wait memory and decode.
module tb_fetch_sequencer;
   logic clk = 1'b0, reset = 1'b1, br_valid = 1'b0;
   logic [1:0] br_ps = 2'b00;
   logic [63:0] br_pc = '0, br_operand = '0;
   logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
   logic [63:0] imem_req_addr, if_pc, if_pc4, fetch_pc;
   logic [31:0] imem_rsp_data = '0, if_instr;
   logic if_valid, if_ready = 1'b0, halted;
   int checks = 0, failures = 0;

   fetch_sequencer dut (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_ps(br_ps), .br_pc(br_pc),
      .br_operand(br_operand), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
      .fetch_pc(fetch_pc), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [63:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Complete fetch of one word at address a, decode accepting immediately.
   task automatic fetch(input logic [63:0] a);
      chk("req_valid", 64'(imem_req_valid), 64'd1);
      chk("req_addr", imem_req_addr, a);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem(a);
      chk("wait_no_req", 64'(imem_req_valid), 64'd0);
      tick();
      imem_rsp_valid = 1'b0;
      chk("if_valid_up", 64'(if_valid), 64'd1);
      chk("if_pc", if_pc, a);
      chk("if_pc4", if_pc4, a + 64'd4);
      chk("if_instr", 64'(if_instr), 64'(mem(a)));
      if_ready = 1'b1;
      tick();
      if_ready = 1'b0;
      chk("if_valid_down", 64'(if_valid), 64'd0);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_if_valid", 64'(if_valid), 64'd0);
      chk("rst_if_pc", if_pc, 64'd0);
      chk("rst_if_pc4", if_pc4, 64'd4);
      chk("rst_if_instr", 64'(if_instr), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_fetch_pc", fetch_pc, 64'd0);
      reset = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) fetch(64'(i));
      // redirect while holding an instruction, decode also ready that cycle
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem(64'd4);
      tick();
      imem_rsp_valid = 1'b0;
      chk("hold_valid", 64'(if_valid), 64'd1);
      chk("hold_pc", if_pc, 64'd4);
      br_valid = 1'b1;
      br_ps = 2'b10;
      br_operand = 64'h100;
      if_ready = 1'b1;
      tick();
      br_valid = 1'b0;
      if_ready = 1'b0;
      chk("redir_clear", 64'(if_valid), 64'd0);
      tick();
      chk("redir_no_replay", 64'(if_valid), 64'd0);
      fetch(64'h100);
      // relative redirect coinciding with request acceptance
      imem_req_ready = 1'b1;
      br_valid = 1'b1;
      br_ps = 2'b11;
      br_pc = 64'h20;
      br_operand = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      imem_req_ready = 1'b0;
      br_valid = 1'b0;
      chk("rel_fetch_pc", fetch_pc, 64'h1C);
      chk("rel_wait_no_req", 64'(imem_req_valid), 64'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem(64'h101);
      tick();
      imem_rsp_valid = 1'b0;
      chk("stale_dropped", 64'(if_valid), 64'd0);
      fetch(64'h1C);
      // halt command while waiting for memory
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      br_valid = 1'b1;
      br_ps = 2'b00;
      tick();
      br_valid = 1'b0;
      chk("halt_pend_not_halted", 64'(halted), 64'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem(64'h1D);
      tick();
      imem_rsp_valid = 1'b0;
      chk("halted", 64'(halted), 64'd1);
      chk("halt_drop", 64'(if_valid), 64'd0);
      for (int i = 0; i < 10; i++) begin
         chk("halt_no_req", 64'(imem_req_valid), 64'd0);
         tick();
      end
      chk("halt_pc_kept", fetch_pc, 64'h1D);
      br_valid = 1'b1;
      br_ps = 2'b01;
      br_pc = 64'h40;
      tick();
      br_valid = 1'b0;
      chk("unhalt", 64'(halted), 64'd0);
      fetch(64'h41);
      // wrap at the top of the address space
      br_valid = 1'b1;
      br_ps = 2'b10;
      br_operand = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      br_valid = 1'b0;
      fetch(64'hFFFF_FFFF_FFFF_FFFF);
      chk("wrap_pc4", if_pc4, 64'd3);
      chk("wrap_addr", imem_req_addr, 64'd0);
      // reset while holding
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem(64'd0);
      tick();
      imem_rsp_valid = 1'b0;
      chk("pre_rst_hold", 64'(if_valid), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_hold_valid", 64'(if_valid), 64'd0);
      chk("rst_hold_pc4", if_pc4, 64'd4);
      tick();
      chk("rst_req_valid", 64'(imem_req_valid), 64'd1);
      chk("rst_req_addr", imem_req_addr, 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
